bvshl_inv_solver: RTL and testbench

Sequential, width-parametrised Skolem solver for bit-vector shift-left equations. Given operands `s` and `t`, it finds `x` such that either `(x << s) == t` (mode 0) or `(s << x) == t` (mode 1). It searches one bit or one candidate per cycle and reports the witness `x` plus a `found` flag. It replaces the fixed 4-bit combinational Skolem netlists in the invertibility-condition flow and is used as a multi-cycle co-processor by the word-level solver.

---
 rtl/bvshl_inv_solver.sv | 165 ++++++++++++++++
 tb/tb_bvshl_inv_solver.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bvshl_inv_solver.sv
// rtl/bvshl_inv_solver.sv - sequential Skolem solver for x<<s==t (mode 0) and s<<x==t (mode 1)
//
// Optional feature macro: BVSHL_INV_EARLY_EXIT_EN
//   defined   : RUN stops as soon as the answer is known (variable latency)
//   undefined : constant-time RUN (WIDTH cycles in mode 0, WIDTH+1 in mode 1)
//
// Ports:
//   clk    in  1      rising-edge clock
//   rst_n  in  1      synchronous active-low reset
//   start  in  1      job request, accepted whenever not busy (IDLE or DONE)
//   mode   in  1      0: solve x<<s==t, 1: solve s<<x==t
//   s      in  WIDTH  operand s, latched on accepted start
//   t      in  WIDTH  target t, latched on accepted start
//   busy   out 1      high while the search runs
//   done   out 1      one-cycle pulse, x/found valid
//   found  out 1      a solution exists
//   x      out WIDTH  witness, 0 when found=0; held until the next accepted start
module bvshl_inv_solver #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] t,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [WIDTH-1:0] x
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    localparam logic [WIDTH-1:0] LP_WN    = WIDTH'(WIDTH);
    localparam logic [WIDTH-1:0] LP_WN_M1 = WIDTH'(WIDTH - 1);
    localparam logic [WIDTH-1:0] LP_ONE   = WIDTH'(1);
    localparam logic [WIDTH:0]   LP_W1    = (WIDTH + 1)'(WIDTH);
    localparam logic [WIDTH:0]   LP_ONE1  = (WIDTH + 1)'(1);

    state_t           r_state;
    logic             r_mode;
    logic [WIDTH-1:0] r_t;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_shcnt;
    logic [WIDTH-1:0] r_xc;
    logic             r_fail;
    logic             r_match;
    logic             r_busy;
    logic             r_done;
    logic             r_found;
    logic [WIDTH-1:0] r_x;

    logic             w_accept;
    logic [WIDTH-1:0] w_shcnt_in;
    logic             w_in_shift;
    logic             w_hit;
    logic [WIDTH-1:0] w_acc_nxt;
    logic             w_fail_nxt;
    logic             w_match_nxt;
    logic [WIDTH-1:0] w_xc_nxt;
    logic             w_last;

    assign w_accept   = start && (r_state != ST_RUN);
    // Shift count saturates at WIDTH; compared at full s width so large s is never truncated.
    assign w_shcnt_in = ({1'b0, s} >= LP_W1) ? LP_WN : s;
    assign w_in_shift = (r_cnt < r_shcnt);
    assign w_hit      = (r_acc == r_t) && !r_match;

    always_comb begin
        w_acc_nxt   = r_acc;
        w_fail_nxt  = r_fail;
        w_match_nxt = r_match;
        w_xc_nxt    = r_xc;
        if (!r_mode) begin
            // Any 1 shifted out below the shift count cannot be produced by x<<s.
            if (w_in_shift) begin
                w_fail_nxt = r_fail | r_acc[0];
                w_acc_nxt  = r_acc >> 1;
            end
        end else begin
            if (w_hit) begin
                w_match_nxt = 1'b1;
                w_xc_nxt    = r_cnt;
            end
            w_acc_nxt = r_acc << 1;
        end
    end

`ifdef BVSHL_INV_EARLY_EXIT_EN
    // Mode 0 stops at the first failing bit or when the shift count is used up (at least one cycle).
    assign w_last = r_mode ? (w_hit || (r_cnt == LP_WN))
                           : ((({1'b0, r_cnt} + LP_ONE1) >= {1'b0, r_shcnt}) ||
                              (w_in_shift && r_acc[0]));
`else
    assign w_last = r_mode ? (r_cnt == LP_WN) : (r_cnt == LP_WN_M1);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_mode  <= 1'b0;
            r_t     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_shcnt <= '0;
            r_xc    <= '0;
            r_fail  <= 1'b0;
            r_match <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_found <= 1'b0;
            r_x     <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_mode  <= mode;
                        r_t     <= t;
                        r_acc   <= mode ? s : t;
                        r_shcnt <= w_shcnt_in;
                        r_cnt   <= '0;
                        r_xc    <= '0;
                        r_fail  <= 1'b0;
                        r_match <= 1'b0;
                        r_found <= 1'b0;
                        r_x     <= '0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_acc   <= w_acc_nxt;
                    r_fail  <= w_fail_nxt;
                    r_match <= w_match_nxt;
                    r_xc    <= w_xc_nxt;
                    r_cnt   <= r_cnt + LP_ONE;
                    if (w_last) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        if (r_mode) begin
                            r_found <= w_match_nxt;
                            r_x     <= w_match_nxt ? w_xc_nxt : '0;
                        end else begin
                            r_found <= !w_fail_nxt;
                            r_x     <= w_fail_nxt ? '0 : w_acc_nxt;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign found = r_found;
    assign x     = r_x;

endmodule

// File: tb/tb_bvshl_inv_solver.sv
// tb/tb_bvshl_inv_solver.sv - self-checking bench for bvshl_inv_solver (WIDTH 4 and 8 instances)
module tb_bvshl_inv_solver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] s8 = '0;
    logic [7:0] t8 = '0;
    logic [3:0] s4, t4;
    logic       busy4, done4, found4;
    logic [3:0] x4;
    logic       busy8, done8, found8;
    logic [7:0] x8;

    assign s4 = s8[3:0];
    assign t4 = t8[3:0];

    always #5 clk = ~clk;

    bvshl_inv_solver #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .s(s4), .t(t4),
        .busy(busy4), .done(done4), .found(found4), .x(x4)
    );

    bvshl_inv_solver #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .s(s8), .t(t8),
        .busy(busy8), .done(done8), .found(found8), .x(x8)
    );

    int n_chk = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: answer from plain arithmetic / brute-force search, plus the expected busy length.
    function automatic void ref_solve(input int w, input bit md, input int sv, input int tv,
                                      output bit f, output int xv, output int r);
        int mask;
        int sh;
        mask = (1 << w) - 1;
        f  = 1'b0;
        xv = 0;
        r  = 0;
        if (!md) begin
            sh = (sv >= w) ? w : sv;
            f  = (((tv >> sh) << sh) == tv);
            xv = f ? (tv >> sh) : 0;
`ifdef BVSHL_INV_EARLY_EXIT_EN
            r = (sh == 0) ? 1 : sh;
            for (int k = sh - 1; k >= 0; k--)
                if (((tv >> k) & 1) == 1) r = k + 1;
`else
            r = w;
`endif
        end else begin
            for (int c = w; c >= 0; c--)
                if (((sv << c) & mask) == tv) begin
                    f  = 1'b1;
                    xv = c;
                end
`ifdef BVSHL_INV_EARLY_EXIT_EN
            r = f ? xv + 1 : w + 1;
`else
            r = w + 1;
`endif
        end
    endfunction

    // Transaction-level model per instance: index 0 = WIDTH 4, index 1 = WIDTH 8.
    int wd[2] = '{4, 8};
    bit m_busy[2], m_done[2], m_found[2], m_rf[2];
    int m_x[2], m_rx[2], m_rem[2];

    always @(posedge clk) begin
        bit f;
        int xv, r, msk;
        for (int i = 0; i < 2; i++) begin
            msk = (1 << wd[i]) - 1;
            if (!rst_n) begin
                m_busy[i] = 0; m_done[i] = 0; m_found[i] = 0; m_x[i] = 0; m_rem[i] = 0;
            end else if (m_rem[i] > 0) begin
                m_rem[i]--;
                if (m_rem[i] == 0) begin
                    m_busy[i] = 0; m_done[i] = 1; m_found[i] = m_rf[i]; m_x[i] = m_rx[i];
                end
            end else begin
                m_done[i] = 0;
                if (start) begin
                    ref_solve(wd[i], mode, int'(s8) & msk, int'(t8) & msk, f, xv, r);
                    m_rf[i] = f; m_rx[i] = xv; m_rem[i] = r;
                    m_busy[i] = 1; m_x[i] = 0; m_found[i] = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy4", 32'(busy4), 32'(m_busy[0]));
            check("done4", 32'(done4), 32'(m_done[0]));
            check("found4", 32'(found4), 32'(m_found[0]));
            check("x4", 32'(x4), m_x[0]);
            check("busy8", 32'(busy8), 32'(m_busy[1]));
            check("done8", 32'(done8), 32'(m_done[1]));
            check("found8", 32'(found8), 32'(m_found[1]));
            check("x8", 32'(x8), m_x[1]);
        end
    end

    task automatic wait_idle(input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy4 && !busy8) begin
                ok = 1'b1;
                break;
            end
        end
        check({nm, "_timeout"}, 32'(ok), 32'd1);
    endtask

    task automatic run_job(input bit md, input int sv, input int tv);
        @(negedge clk);
        start = 1'b1; mode = md; s8 = 8'(sv); t8 = 8'(tv);
        @(negedge clk);
        start = 1'b0;
        wait_idle("job");
    endtask

    int  d_w[8]  = '{0, 0, 0, 0, 0, 0, 1, 1};
    bit  d_m[8]  = '{0, 0, 1, 1, 1, 1, 0, 0};
    int  d_s[8]  = '{1, 2, 3, 1, 0, 3, 9, 9};
    int  d_t[8]  = '{6, 6, 12, 0, 0, 5, 0, 1};
    bit  d_f[8]  = '{1, 0, 1, 1, 1, 0, 1, 0};
    int  d_x[8]  = '{3, 0, 2, 4, 0, 0, 0, 0};
`ifdef BVSHL_INV_EARLY_EXIT_EN
    int  d_r[3]  = '{1, 2, 3};
`else
    int  d_r[3]  = '{4, 4, 5};
`endif

    initial begin
        bit f;
        int xv, r, ok;
        // Pin the reference model with hand-computed answers.
        for (int i = 0; i < 8; i++) begin
            ref_solve(wd[d_w[i]], d_m[i], d_s[i], d_t[i], f, xv, r);
            check($sformatf("pin%0d_found", i), 32'(f), 32'(d_f[i]));
            check($sformatf("pin%0d_x", i), xv, d_x[i]);
            if (i < 3) check($sformatf("pin%0d_lat", i), r, d_r[i]);
        end

        repeat (3) @(posedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        check("rst_busy", 32'(busy4), 0);
        check("rst_x", 32'(x8), 0);
        rst_n = 1'b1;

        // Directed jobs checked against literal answers.
        for (int i = 0; i < 8; i++) begin
            run_job(d_m[i], d_s[i], d_t[i]);
            check($sformatf("dir%0d_found", i), d_w[i] ? 32'(found8) : 32'(found4), 32'(d_f[i]));
            check($sformatf("dir%0d_x", i), d_w[i] ? 32'(x8) : 32'(x4), d_x[i]);
        end

        // Start while busy is ignored.
        @(negedge clk);
        start = 1'b1; mode = 1'b0; s8 = 8'd1; t8 = 8'd6;
        @(negedge clk);
        s8 = 8'd2; t8 = 8'd5; mode = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("ign");
        check("ign_found", 32'(found4), 1);
        check("ign_x", 32'(x4), 3);

        // Reset mid-run aborts without done.
        @(negedge clk);
        start = 1'b1; mode = 1'b1; s8 = 8'd3; t8 = 8'd12;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy4), 0);
        check("abort_done", 32'(done4), 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Start held through DONE: next job begins with no idle gap.
        start = 1'b1; mode = 1'b1; s8 = 8'd3; t8 = 8'd12;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done4) begin
                ok = 1;
                break;
            end
        end
        check("b2b_done_seen", ok, 1);
        @(negedge clk);
        check("b2b_busy", 32'(busy4), 1);
        start = 1'b0;
        wait_idle("b2b");

        // Randomized traffic, including held starts and occasional resets.
        for (int cyc = 0; cyc < 20000; cyc++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 499) != 0);
            start = ($urandom_range(0, 3) == 0);
            mode  = 1'($urandom_range(0, 1));
            s8    = $urandom_range(0, 1) ? 8'($urandom_range(0, 10)) : 8'($urandom);
            case ($urandom_range(0, 3))
                0: t8 = 8'($urandom);
                1: t8 = 8'd0;
                2: t8 = 8'(s8 << $urandom_range(0, 8));
                default: t8 = 8'($urandom << s8[2:0]);
            endcase
        end
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        wait_idle("final");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
